// File: rtl/vdc_pkg.sv
// rtl/vdc_pkg.sv - shared van der Corput constants, base encodings and FSM states
package vdc_pkg;

  localparam logic [1:0] BSEL_2 = 2'b00;
  localparam logic [1:0] BSEL_3 = 2'b01;
  localparam logic [1:0] BSEL_5 = 2'b10;
  localparam logic [1:0] BSEL_7 = 2'b11;

  // Digit count N and modulus P = base^N, chosen so P <= 2^16 for each base.
  localparam int unsigned VDC_B [4] = '{2, 3, 5, 7};
  localparam int unsigned VDC_N [4] = '{16, 10, 6, 5};
  localparam int unsigned VDC_P [4] = '{65536, 59049, 15625, 16807};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCALE = 2'd1,
    ST_DIGIT = 2'd2,
    ST_DONE  = 2'd3
  } vdc_state_e;

endpackage

// File: rtl/vdc_const_divmod.sv
// rtl/vdc_const_divmod.sv - combinational 16-bit divide/modulo by base 2/3/5/7
module vdc_const_divmod
  import vdc_pkg::*;
(
  input  logic [15:0] dividend,
  input  logic [1:0]  base_sel,
  output logic [15:0] quotient,
  output logic [2:0]  remainder
);

  always_comb begin
    quotient  = '0;
    remainder = '0;
    unique case (base_sel)
      BSEL_2: begin
        quotient  = dividend >> 1;
        remainder = {2'b00, dividend[0]};
      end
      BSEL_3: begin
        quotient  = dividend / 16'd3;
        remainder = 3'(dividend % 16'd3);
      end
      BSEL_5: begin
        quotient  = dividend / 16'd5;
        remainder = 3'(dividend % 16'd5);
      end
      default: begin
        quotient  = dividend / 16'd7;
        remainder = 3'(dividend % 16'd7);
      end
    endcase
  end

endmodule

// File: rtl/vdcorput_inverse_fsm.sv
// rtl/vdcorput_inverse_fsm.sv - sequential inverse of the van der Corput core
// Recovers k mod P from a truncated 16.16 sequence value by digit reversal.
module vdcorput_inverse_fsm
  import vdc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] x_in,
  input  logic [1:0]  base_sel,
  output logic [31:0] k_out,
  output logic        done,
  output logic        ready
);

  vdc_state_e  state_q, state_d;
  logic [15:0] frac_q, frac_d;
  logic [1:0]  bsel_q, bsel_d;
  logic [15:0] m_q, m_d;
  logic [16:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] k_out_q, k_out_d;

  logic [32:0] scale_sum;
  logic [16:0] m_ceil;
  logic [15:0] dm_q;
  logic [2:0]  dm_r;

  logic unused_bits;
  assign unused_bits = ^{x_in[31:16], scale_sum[15:0]};

  vdc_const_divmod u_divmod (
    .dividend  (m_q),
    .base_sel  (bsel_q),
    .quotient  (dm_q),
    .remainder (dm_r)
  );

  // Ceiling undoes the forward core's truncation; the error is below one step of m.
  assign scale_sum = {17'b0, frac_q} * 33'(VDC_P[bsel_q]) + 33'h0_FFFF;
  assign m_ceil    = scale_sum[32:16];

  always_comb begin
    state_d = state_q;
    frac_d  = frac_q;
    bsel_d  = bsel_q;
    m_d     = m_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    k_out_d = k_out_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          frac_d  = x_in[15:0];
          bsel_d  = base_sel;
          state_d = ST_SCALE;
        end
      end
      ST_SCALE: begin
        m_d     = (m_ceil == 17'(VDC_P[bsel_q])) ? 16'd0 : m_ceil[15:0];
        acc_d   = '0;
        cnt_d   = 5'(VDC_N[bsel_q]);
        state_d = ST_DIGIT;
      end
      ST_DIGIT: begin
        m_d   = dm_q;
        acc_d = acc_q * 17'(VDC_B[bsel_q]) + 17'(dm_r);
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          k_out_d = {15'b0, acc_d};
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      frac_q  <= '0;
      bsel_q  <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      k_out_q <= '0;
    end else begin
      state_q <= state_d;
      frac_q  <= frac_d;
      bsel_q  <= bsel_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      k_out_q <= k_out_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign k_out = k_out_q;

endmodule
